// File: rtl/me_unaligned_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : me_unaligned_rd_ctrl
// Brief    : ME-stage load controller. Issues one or two 16-byte D-cache line
//            requests per load, depending on whether the access crosses a line
//            boundary. It then extracts the addressed bytes as right-justified,
//            zero-extended read data, and holds it until write-back accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module me_unaligned_rd_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         v,
    input  logic         mem_rd,
    input  logic [31:0]  rd_addr,
    input  logic [1:0]   mem_size,
    input  logic         flush,
    input  logic         ld_wb,
    input  logic         dc_ready,
    input  logic [127:0] dc_data,
    output logic         dc_req,
    output logic [31:0]  dc_addr,
    output logic [63:0]  rd_data,
    output logic         rd_data_v,
    output logic         me_stall
);

    localparam logic [4:0] c_line_bytes = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ1 = 2'd1,
        ST_REQ2 = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [31:0]    r_addr;
    logic [1:0]     r_size;
    logic           r_cross;
    logic           r_flushed;   // squash seen while a line request was outstanding
    logic [127:0]   r_buf0;
    logic [127:0]   r_buf1;

    logic           w_accept;
    logic [4:0]     w_in_bytes;
    logic           w_in_cross;
    logic           w_cap0;
    logic           w_cap1;
    logic [4:0]     w_nbytes;
    logic [255:0]   w_line;
    logic [63:0]    w_data;
    logic           w_valid;

    // Accept decode and line-crossing test on the incoming uop (5-bit sum so 16 is representable)
    always_comb begin
        w_accept   = v & mem_rd & ~flush;
        w_in_bytes = 5'd1 << mem_size;
        w_in_cross = (({1'b0, rd_addr[3:0]} + w_in_bytes) > c_line_bytes);
    end

    // Next-state, request and stall decode
    always_comb begin
        w_next   = r_state;
        w_cap0   = 1'b0;
        w_cap1   = 1'b0;
        dc_req   = 1'b0;
        dc_addr  = 32'h0;
        me_stall = 1'b0;
        w_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                me_stall = w_accept;
                if (w_accept) begin
                    w_next = ST_REQ1;
                end
            end
            ST_REQ1: begin
                dc_req   = 1'b1;
                dc_addr  = {r_addr[31:4], 4'h0};
                me_stall = 1'b1;
                if (dc_ready) begin
                    w_cap0 = 1'b1;
                    if (flush | r_flushed) begin
                        w_next = ST_IDLE;
                    end else if (r_cross) begin
                        w_next = ST_REQ2;
                    end else begin
                        w_next = ST_HOLD;
                    end
                end
            end
            ST_REQ2: begin
                dc_req   = 1'b1;
                dc_addr  = {r_addr[31:4] + 28'd1, 4'h0};
                me_stall = 1'b1;
                if (dc_ready) begin
                    w_cap1 = 1'b1;
                    w_next = (flush | r_flushed) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                me_stall = ~ld_wb;
                w_valid  = ~flush;
                if (flush | ld_wb) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Byte extraction: shift the two-line window by the offset, keep only the first N bytes
    always_comb begin
        w_line   = {r_buf1, r_buf0};
        w_nbytes = 5'd1 << r_size;
        w_data   = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (5'(i) < w_nbytes) begin
                w_data[i*8 +: 8] = w_line[{({1'b0, r_addr[3:0]} + 5'(i)), 3'b000} +: 8];
            end
        end
        rd_data_v = w_valid;
        rd_data   = w_valid ? w_data : 64'h0;
    end

    // State, latched uop attributes and returned line buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= 32'h0;
            r_size    <= 2'b00;
            r_cross   <= 1'b0;
            r_flushed <= 1'b0;
            r_buf0    <= 128'h0;
            r_buf1    <= 128'h0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_accept) begin
                r_addr  <= rd_addr;
                r_size  <= mem_size;
                r_cross <= w_in_cross;
            end
            if (w_next == ST_IDLE) begin
                r_flushed <= 1'b0;
            end else if (((r_state == ST_REQ1) || (r_state == ST_REQ2)) && flush) begin
                r_flushed <= 1'b1;
            end
            if (w_cap0) begin
                r_buf0 <= dc_data;
            end
            if (w_cap1) begin
                r_buf1 <= dc_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/me_unaligned_rd_ctrl.md
ME_UNALIGNED_RD_CTRL -- requirements
Module: me_unaligned_rd_ctrl

Interface
REQ-001 No parameters; D-cache line is fixed at 16 bytes.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset; synchronous and active-high.
REQ-004 V  in  1  valid uop present in ME stage.
REQ-005 MEM_RD  in  1  uop reads memory (AG D2_MEM_RD_ME).
REQ-006 RD_ADDR  in  32  linear read address from AG MEM_RD_ADDR.
REQ-007 MEM_SIZE  in  2  00=1B, 01=2B, 10=4B, 11=8B.
REQ-008 FLUSH  in  1  squash current uop.
REQ-009 LD_WB  in  1  WB latch accepts this cycle.
REQ-010 DC_READY  in  1  D-cache returns line this cycle.
REQ-011 DC_DATA  in  128  returned line; byte k at bits [8k+7:8k].
REQ-012 DC_REQ  out  1  D-cache read request.
REQ-013 DC_ADDR  out  32  line-aligned request address, bits [3:0]=0.
REQ-014 RD_DATA  out  64  read data, right-justified, zero-extended above size.
REQ-015 RD_DATA_V  out  1  RD_DATA valid for WB.
REQ-016 ME_STALL  out  1  hold AG/ME latches.

Function
REQ-017 States: IDLE, REQ1, REQ2, HOLD; encoding free.
REQ-018 Size bytes N = 1,2,4,8; CROSS = (RD_ADDR[3:0] + N) > 16, computed 5 bits wide.
REQ-019 IDLE: V & MEM_RD & ~FLUSH -> latch RD_ADDR, MEM_SIZE, CROSS; go REQ1; else stay.
REQ-020 REQ1: DC_REQ=1, DC_ADDR={addr[31:4],4'h0}; on DC_READY capture DC_DATA to BUF0; go REQ2 if CROSS else HOLD.
REQ-021 REQ2: DC_REQ=1, DC_ADDR={addr[31:4]+1 mod 2^28,4'h0}; on DC_READY capture BUF1; go HOLD.
REQ-022 DC_REQ and DC_ADDR held constant from request until DC_READY.
REQ-023 HOLD: RD_DATA_V=1; RD_DATA = low 64 bits of {BUF1,BUF0} >> (8*addr[3:0]), bytes >= N forced 0; LD_WB=1 -> IDLE, else remain with data stable.
REQ-024 ME_STALL = (IDLE & V & MEM_RD & ~FLUSH) | REQ1 | REQ2 | (HOLD & ~LD_WB).
REQ-025 Latency: non-crossing with immediate DC_READY -> RD_DATA_V 2 cycles after IDLE accept; crossing -> 3 cycles; each DC_READY wait cycle adds 1.
REQ-026 Non-memory or invalid uops (V=0 or MEM_RD=0) pass with ME_STALL=0, no DC_REQ.
REQ-027 FLUSH in REQ1/REQ2: outstanding request held until DC_READY, data discarded, then IDLE; no second-line request; RD_DATA_V never asserted.
REQ-028 FLUSH in HOLD: IDLE next cycle, RD_DATA_V=0 same cycle.
REQ-029 FLUSH and DC_READY same cycle: transaction completes and is discarded -> IDLE.
REQ-030 Boundaries: 8B at offset 8 is non-crossing; offset 9 crossing; 1B never crosses.
REQ-031 Second-line address wraps: line 0xFFFFFFF0 followed by 0x00000000.
REQ-032 BUF1 don't-care when CROSS=0; contributes no bytes to RD_DATA.

Reset
REQ-033 RST=1 at edge: state IDLE, BUF0/BUF1/latched addr/size/CROSS cleared to 0.
REQ-034 During and after reset: DC_REQ=0, DC_ADDR=0, RD_DATA=0, RD_DATA_V=0; ME_STALL follows REQ-024 with state IDLE.
REQ-035 RST mid-transaction abandons it; late DC_READY in IDLE ignored.

Verification
REQ-036 4B at 0x00001004, DC_DATA byte k=k, DC_READY immediate -> one DC_REQ addr 0x00001000; RD_DATA=0x0000000007060504, RD_DATA_V 2 cycles after accept.
REQ-037 4B at 0x0000100E, line0 byte k=k, line1 byte k=0x10+k -> DC_REQ 0x00001000 then 0x00001010; RD_DATA=0x0000000011100F0E at cycle 3.
REQ-038 8B at 0x00001008 -> one request, RD_DATA=0x0F0E0D0C0B0A0908; 8B at 0x00001009 -> two requests, RD_DATA=0x100F0E0D0C0B0A09.
REQ-039 2B at 0xFFFFFFFF -> requests 0xFFFFFFF0 then 0x00000000; RD_DATA=0x00000000000000(line1 byte0)(line0 byteF).
REQ-040 HOLD with LD_WB=0 for 3 cycles -> RD_DATA/RD_DATA_V stable, ME_STALL=1; LD_WB=1 -> IDLE, ME_STALL=0 next cycle.
REQ-041 FLUSH in REQ1 of crossing read, DC_READY delayed 2 cycles -> DC_REQ held 0x00001000, no 0x00001010 request, RD_DATA_V=0; RST in REQ2 -> DC_REQ=0 next cycle.
